// File: rtl/uart_tx_arbiter_pkg.sv
// Shared encodings and helpers for the UART transmit arbiter (package uart_arb_pkg).
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Command bytes produced by the button encoder on source A.
  localparam logic [7:0] CMD_1 = 8'h01;
  localparam logic [7:0] CMD_2 = 8'h02;
  localparam logic [7:0] CMD_3 = 8'h03;
  localparam logic [7:0] CMD_4 = 8'h04;
  localparam logic [7:0] CMD_5 = 8'h05;
  localparam logic [7:0] CMD_6 = 8'h06;
  localparam logic [7:0] CMD_7 = 8'h07;
  localparam logic [7:0] CMD_8 = 8'h08;

  localparam int DEF_GAP_TICKS     = 16;
  localparam int DEF_TIMEOUT_TICKS = 4096;
  localparam int DEF_CNT_W         = 13;

  // Round-robin pick: a lone requester wins, otherwise the source that did not own the last byte.
  function automatic logic pick_b(input logic a_valid, input logic b_valid, input logic last_b);
    return b_valid && !(a_valid && last_b);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source handshakes, UART tx hookup and status flags of the transmit arbiter.
interface uart_tx_arbiter_if;
  logic       tick;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       busy;
  logic       grant_b;
  logic       timeout_err;
  logic       dup_drop;

  modport slave (
    input  tick, a_valid, a_data, b_valid, b_data, tx_done,
    output a_ready, b_ready, tx_en, tx_data, busy, grant_b, timeout_err, dup_drop
  );

  modport master (
    output tick, a_valid, a_data, b_valid, b_data, tx_done,
    input  a_ready, b_ready, tx_en, tx_data, busy, grant_b, timeout_err, dup_drop
  );
endinterface

// File: rtl/uart_tx_arbiter_tick_counter.sv
// Baud-tick counter shared by the SEND timeout and the post-byte GAP; clear beats tick.
module uart_tick_counter #(
  parameter int CNT_W = 13
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick_en,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick_en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit = (count_q == limit);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte sources.
// Optional macro TX_DEDUP_EN suppresses a byte equal to the last one transmitted.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int GAP_TICKS     = DEF_GAP_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] GAP_LIM     = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_TICKS);

  arb_state_e state_q, state_d;
  logic       tx_en_q, tx_en_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       busy_q, busy_d;
  logic       grant_b_q, grant_b_d;
  logic       err_q, err_d;
  logic       dup_q, dup_d;

  logic [1:0] src_valid;
  logic [1:0] src_ready;
  logic [7:0] src_data [2];
  logic       idle_ok;
  logic       sel_b;
  logic       xfer;
  logic [7:0] xfer_data;
  logic       is_dup;

  logic             cnt_clear;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_at_limit;

  assign src_valid   = {bus.b_valid, bus.a_valid};
  assign src_data[0] = bus.a_data;
  assign src_data[1] = bus.b_data;

  // Ready never rises during reset so a held byte cannot slip in while the arbiter is cleared.
  assign idle_ok = (state_q == ST_IDLE) && !reset;
  assign sel_b   = pick_b(bus.a_valid, bus.b_valid, grant_b_q);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_ready[gi] = idle_ok && src_valid[gi] && (sel_b == 1'(gi));
    end
  endgenerate

  assign bus.a_ready = src_ready[0];
  assign bus.b_ready = src_ready[1];
  assign xfer        = |src_ready;
  assign xfer_data   = src_data[sel_b];

`ifdef TX_DEDUP_EN
  // tx_data only ever changes when a byte is really transmitted, so it is the last-sent memory.
  assign is_dup = (xfer_data == tx_data_q);
`else
  assign is_dup = 1'b0;
`endif

  assign cnt_limit = (state_q == ST_SEND) ? TIMEOUT_LIM : GAP_LIM;
  assign cnt_clear = (state_q == ST_IDLE) || (state_d != state_q);

  uart_tick_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .tick_en  (bus.tick),
    .limit    (cnt_limit),
    .at_limit (cnt_at_limit)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    grant_b_d = grant_b_q;
    err_d     = err_q;
    dup_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          grant_b_d = sel_b;
          if (is_dup) begin
            dup_d = 1'b1;
          end else begin
            tx_data_d = xfer_data;
            state_d   = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        // A completion arriving on the limit cycle still counts as success.
        if (bus.tx_done) begin
          state_d = ST_GAP;
        end else if (cnt_at_limit) begin
          err_d   = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_at_limit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tx_en_d = (state_d == ST_SEND);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      grant_b_q <= SRC_B;
      err_q     <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      grant_b_q <= grant_b_d;
      err_q     <= err_d;
      dup_q     <= dup_d;
    end
  end

  assign bus.tx_en       = tx_en_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = busy_q;
  assign bus.grant_b     = grant_b_q;
  assign bus.timeout_err = err_q;
  assign bus.dup_drop    = dup_q;

endmodule
